// File: rtl/sram_pkg.sv
// Shared SRAM geometry for the column datapath.
//   COLS       : data bits per SRAM column word
//   CNT_W      : width of a counter able to hold 0..COLS
//   col_word_t : one column word
package sram_pkg;

    localparam int unsigned COLS  = 8;
    localparam int unsigned CNT_W = $clog2(COLS + 1);

    typedef logic [COLS-1:0] col_word_t;

endpackage : sram_pkg

// File: rtl/sipo_frame_if.sv
// Bundle of the serial input side and the valid/ready word output side of sipo_frame.
//   serial_in, bit_valid, frame_start : serial stream from the line side
//   out_ready                         : consumer accepts the presented word
//   parallel_out, out_valid           : assembled word and its valid flag
//   bit_cnt                           : bits collected in the current frame
//   overrun, parity_err               : dropped-frame pulse, parity result of parallel_out
// Modports: slave = deserializer view, master = producer/consumer view.
interface sipo_frame_if #(
    parameter int unsigned COLS = sram_pkg::COLS
) ();

    localparam int unsigned CntW = $clog2(COLS + 1);

    logic            serial_in;
    logic            bit_valid;
    logic            frame_start;
    logic            out_ready;
    logic [COLS-1:0] parallel_out;
    logic            out_valid;
    logic [CntW-1:0] bit_cnt;
    logic            overrun;
    logic            parity_err;

    modport slave (
        input  serial_in,
        input  bit_valid,
        input  frame_start,
        input  out_ready,
        output parallel_out,
        output out_valid,
        output bit_cnt,
        output overrun,
        output parity_err
    );

    modport master (
        output serial_in,
        output bit_valid,
        output frame_start,
        output out_ready,
        input  parallel_out,
        input  out_valid,
        input  bit_cnt,
        input  overrun,
        input  parity_err
    );

endinterface : sipo_frame_if

// File: rtl/sipo_frame.sv
// Serial-to-parallel deserializer: collects a frame of COLS serial bits into one column
// word and offers it on a valid/ready output slot. A new frame may shift in while the
// previous word waits; a frame completing against an occupied, non-draining slot is
// dropped and flagged with a one-cycle overrun pulse.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sipo_frame_if.slave (serial inputs, word output handshake, status)
// Parameters:
//   COLS      : word width (>= 2)
//   MSB_FIRST : 1 = first received bit lands in parallel_out[COLS-1], 0 = in [0]
// Build option: define SIPO_PARITY_EN to append an even-parity bit to every frame;
// parity_err then reports XOR of data and parity for the word in parallel_out.
module sipo_frame #(
    parameter int unsigned COLS      = sram_pkg::COLS,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    sipo_frame_if.slave   bus
);

    localparam int unsigned CntW = $clog2(COLS + 1);
`ifdef SIPO_PARITY_EN
    localparam int unsigned FLEN = COLS + 1;
`else
    localparam int unsigned FLEN = COLS;
`endif
    localparam logic [CntW-1:0] LastIdx = CntW'(FLEN - 1);

    logic [COLS-1:0] sr_q;
    logic [COLS-1:0] sr_base;
    logic [COLS-1:0] sr_shift;
    logic [COLS-1:0] word_d;
    logic [COLS-1:0] data_q;
    logic [CntW-1:0] cnt_q;
    logic            valid_q;
    logic            overrun_q;
    logic            perr_q;
    logic            perr_d;
    logic            complete;
    logic            take_bit;

    always_comb begin
        // frame_start discards the partial frame before the current bit is shifted in
        sr_base = bus.frame_start ? '0 : sr_q;
        if (MSB_FIRST != 0) begin
            sr_shift = {sr_base[COLS-2:0], bus.serial_in};
        end else begin
            sr_shift = {bus.serial_in, sr_base[COLS-1:1]};
        end
        complete = bus.bit_valid && !bus.frame_start && (cnt_q == LastIdx);
`ifdef SIPO_PARITY_EN
        // The trailing parity bit is never stored; the word is already complete in sr_q
        take_bit = bus.bit_valid && (bus.frame_start || (cnt_q < CntW'(COLS)));
        word_d   = sr_q;
        perr_d   = (^sr_q) ^ bus.serial_in;
`else
        take_bit = bus.bit_valid;
        word_d   = sr_shift;
        perr_d   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            if (take_bit) begin
                sr_q <= sr_shift;
            end else if (bus.frame_start) begin
                sr_q <= '0;
            end

            if (bus.frame_start) begin
                cnt_q <= bus.bit_valid ? CntW'(1) : '0;
            end else if (complete) begin
                cnt_q <= '0;
            end else if (bus.bit_valid) begin
                cnt_q <= cnt_q + CntW'(1);
            end

            if (complete) begin
                // A slot being drained this cycle counts as free
                if (!valid_q || bus.out_ready) begin
                    data_q  <= word_d;
                    perr_q  <= perr_d;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.parallel_out = data_q;
    assign bus.out_valid    = valid_q;
    assign bus.bit_cnt      = cnt_q;
    assign bus.overrun      = overrun_q;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err   = perr_q;
`else
    assign bus.parity_err   = 1'b0;
`endif

endmodule : sipo_frame
